// File: rtl/etroc1_trigger_event_builder_pkg.sv
// etroc1_trigger_event_builder_pkg: marker tags, FSM state encoding and
// header/trailer word packing shared by the event builder and its bench.
package etroc1_trigger_event_builder_pkg;
    localparam logic [3:0] HDR_TAG_DEF = 4'hA;
    localparam logic [3:0] TRL_TAG_DEF = 4'hB;
    localparam int TAG_LSB  = 28;
    localparam int BID_LSB  = 24;
    localparam int WLEN_LSB = 16;
    localparam int NZ_LSB   = 16;
    localparam int LOW_LSB  = 0;

    typedef enum logic [1:0] {IDLE, CAPTURE, TRAILER} state_e;

    // header: tag | board | 4'h0 | window_len | evt_cnt
    function automatic logic [31:0] pack_header(logic [3:0] tag, logic [3:0] bid,
                                                logic [3:0] wlen, logic [15:0] cnt);
        return (32'(tag) << TAG_LSB) | (32'(bid) << BID_LSB) |
               (32'(wlen) << WLEN_LSB) | (32'(cnt) << LOW_LSB);
    endfunction

    // trailer: tag | board | nonzero count | xor checksum
    function automatic logic [31:0] pack_trailer(logic [3:0] tag, logic [3:0] bid,
                                                 logic [7:0] nz, logic [15:0] xsum);
        return (32'(tag) << TAG_LSB) | (32'(bid) << BID_LSB) |
               (32'(nz) << NZ_LSB) | (32'(xsum) << LOW_LSB);
    endfunction
endpackage

// File: rtl/etroc1_trigger_event_builder_if.sv
// etroc1_trigger_event_builder_if: valid/ready event word stream.
interface etroc1_trigger_event_builder_if;
    logic [31:0] evt_data;
    logic        evt_valid;
    logic        evt_ready;
    modport master (output evt_data, output evt_valid, input evt_ready);
    modport slave  (input evt_data, input evt_valid, output evt_ready);
endinterface

// File: rtl/etroc1_trigger_event_builder_fifo.sv
// etroc_sync_fifo: 32-bit show-ahead synchronous FIFO exposing its occupancy.
module etroc_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [31:0]   wdata_i,
    input  logic          pop_i,
    output logic [31:0]   rdata_o,
    output logic          valid_o,
    output logic [AW:0]   count_o
);
    logic [31:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign valid_o = cnt_q != '0;
    assign rdata_o = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    // upstream admission control must make this unreachable
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push_i && cnt_q == (AW+1)'(DEPTH)));
    end
endmodule

// File: rtl/etroc1_trigger_event_builder.sv
// etroc1_trigger_event_builder: per-L1 cache readout framed as header/data/trailer
// words in an event FIFO drained over a valid/ready stream.
module etroc1_trigger_event_builder
    import etroc1_trigger_event_builder_pkg::*;
#(
    parameter int         FIFO_DEPTH = 64,
    parameter logic [3:0] HDR_TAG    = HDR_TAG_DEF,
    parameter logic [3:0] TRL_TAG    = TRL_TAG_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        l1_trig_i,
    input  logic [3:0]  window_len_i,
    input  logic [3:0]  board_id_i,
    output logic        cache_trig_o,
    input  logic [31:0] cache_dout_i,
    output logic        busy_o,
    output logic [15:0] evt_cnt_o,
    output logic [15:0] trig_dropped_cnt_o,
    etroc1_trigger_event_builder_if.master evt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_e state_q, state_d;
    logic [3:0] idx_q, idx_d, wlen_q, wlen_d, bid_q, bid_d;
    logic [15:0] xsum_q, xsum_d, evt_cnt_q, evt_cnt_d, drop_q, drop_d;
    logic [7:0] nz_q, nz_d;
    logic push, room;
    logic [31:0] wdata;
    logic [AW:0] occ;

    etroc_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (evt.evt_ready),
        .rdata_o (evt.evt_data),
        .valid_o (evt.evt_valid),
        .count_o (occ)
    );

    // whole event (header + N data + trailer) must fit, judged before this cycle's pop
    assign room = (AW+1)'(FIFO_DEPTH) - occ >= (AW+1)'(window_len_i) + (AW+1)'(3);

    assign cache_trig_o       = state_q == CAPTURE;
    assign busy_o             = state_q != IDLE;
    assign evt_cnt_o          = evt_cnt_q;
    assign trig_dropped_cnt_o = drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wlen_q    <= '0;
            bid_q     <= '0;
            xsum_q    <= '0;
            nz_q      <= '0;
            evt_cnt_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wlen_q    <= wlen_d;
            bid_q     <= bid_d;
            xsum_q    <= xsum_d;
            nz_q      <= nz_d;
            evt_cnt_q <= evt_cnt_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wlen_d    = wlen_q;
        bid_d     = bid_q;
        xsum_d    = xsum_q;
        nz_d      = nz_q;
        evt_cnt_d = evt_cnt_q;
        drop_d    = drop_q;
        push      = 1'b0;
        wdata     = '0;
        case (state_q)
            IDLE: if (l1_trig_i && room) begin
                push      = 1'b1;
                wdata     = pack_header(HDR_TAG, board_id_i, window_len_i, evt_cnt_q);
                evt_cnt_d = evt_cnt_q + 16'd1;
                wlen_d    = window_len_i;
                bid_d     = board_id_i;
                xsum_d    = '0;
                nz_d      = '0;
                idx_d     = '0;
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                push    = 1'b1;
                wdata   = cache_dout_i;
                xsum_d  = xsum_q ^ cache_dout_i[31:16] ^ cache_dout_i[15:0];
                nz_d    = nz_q + 8'(cache_dout_i != '0);
                idx_d   = idx_q + 4'd1;
                state_d = idx_q == wlen_q ? TRAILER : CAPTURE;
            end
            TRAILER: begin
                push    = 1'b1;
                wdata   = pack_trailer(TRL_TAG, bid_q, nz_q, xsum_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (l1_trig_i && !(state_q == IDLE && room) && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end
endmodule

// File: tb/tb_etroc1_trigger_event_builder.sv
// tb_etroc1_trigger_event_builder: directed and random triggers checked against an
// event-level reference model that predicts whole events at trigger acceptance.
module tb_etroc1_trigger_event_builder;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        l1_trig = 1'b0;
    logic [3:0]  window_len = '0;
    logic [3:0]  board_id = '0;
    logic        cache_trig;
    logic [31:0] cache_dout;
    logic        busy;
    logic [15:0] evt_cnt, drop_cnt;

    etroc1_trigger_event_builder_if evt_if ();

    etroc1_trigger_event_builder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .l1_trig_i          (l1_trig),
        .window_len_i       (window_len),
        .board_id_i         (board_id),
        .cache_trig_o       (cache_trig),
        .cache_dout_i       (cache_dout),
        .busy_o             (busy),
        .evt_cnt_o          (evt_cnt),
        .trig_dropped_cnt_o (drop_cnt),
        .evt                (evt_if)
    );

    always #5 clk = ~clk;

    // data cache: returns successive words while triggered, 0 otherwise
    logic [31:0] cache_mem [256];
    logic [7:0]  cache_rd = '0;
    assign cache_dout = cache_trig ? cache_mem[cache_rd] : 32'h0;
    always @(posedge clk) if (cache_trig) cache_rd <= cache_rd + 8'd1;

    int vec = 0;
    int miss = 0;
    int rem = 0;
    logic [15:0] m_evt = '0, m_drop = '0, m_xs;
    logic [7:0]  m_rd = '0;
    logic [31:0] m_w;
    int          m_nz;
    logic [31:0] exp_q[$];
    logic [31:0] seen_q[$];

    // reference model: decides admission per the spec rules and queues whole events
    always @(negedge clk) begin
        if (!reset_n) begin
            vec++;
            if ({busy, cache_trig, evt_if.evt_valid, evt_cnt, drop_cnt, evt_if.evt_data} !== '0) begin
                miss++;
                $display("FAIL reset_outputs: got busy=%b cache_trig=%b valid=%b evt_cnt=%h drop=%h data=%h, required all 0",
                         busy, cache_trig, evt_if.evt_valid, evt_cnt, drop_cnt, evt_if.evt_data);
            end
            rem = 0;
            m_evt = '0;
            m_drop = '0;
            m_rd = cache_rd;
            exp_q.delete();
        end else begin
            vec += 4;
            if (busy !== (rem > 0)) begin
                miss++;
                $display("FAIL busy: got %b, required %b", busy, rem > 0);
            end
            if (cache_trig !== (rem >= 2)) begin
                miss++;
                $display("FAIL cache_trig: got %b, required %b", cache_trig, rem >= 2);
            end
            if (evt_cnt !== m_evt) begin
                miss++;
                $display("FAIL evt_cnt: got %h, required %h", evt_cnt, m_evt);
            end
            if (drop_cnt !== m_drop) begin
                miss++;
                $display("FAIL trig_dropped_cnt: got %h, required %h", drop_cnt, m_drop);
            end
            if (rem > 0) begin
                if (l1_trig && m_drop != 16'hFFFF) m_drop++;
                rem--;
            end else if (l1_trig) begin
                if (DEPTH - exp_q.size() >= int'(window_len) + 3) begin
                    exp_q.push_back({4'hA, board_id, 4'h0, window_len, m_evt});
                    m_xs = '0;
                    m_nz = 0;
                    for (int i = 0; i <= int'(window_len); i++) begin
                        m_w = cache_mem[m_rd];
                        m_rd++;
                        m_xs ^= m_w[31:16] ^ m_w[15:0];
                        if (m_w != 0) m_nz++;
                        exp_q.push_back(m_w);
                    end
                    exp_q.push_back({4'hB, board_id, 8'(m_nz), m_xs});
                    m_evt++;
                    rem = int'(window_len) + 2;
                end else if (m_drop != 16'hFFFF) m_drop++;
            end
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                vec++;
                if (exp_q.size() == 0) begin
                    miss++;
                    $display("FAIL evt_data: got %h, required no word", evt_if.evt_data);
                end else begin
                    if (evt_if.evt_data !== exp_q[0]) begin
                        miss++;
                        $display("FAIL evt_data: got %h, required %h", evt_if.evt_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                seen_q.push_back(evt_if.evt_data);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        l1_trig = 1'b1;
        tick(1);
        l1_trig = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int k = 0;
        while (exp_q.size() > 0 && k < 2000) begin
            tick(1);
            k++;
        end
        vec++;
        if (exp_q.size() > 0) begin
            miss++;
            $display("FAIL %s_drain: got %0d words pending, required 0", name, exp_q.size());
        end
        tick(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        vec++;
        if ({busy, cache_trig, evt_if.evt_valid, evt_cnt, drop_cnt} !== '0) begin
            miss++;
            $display("FAIL reset_state: got busy=%b trig=%b valid=%b cnt=%h drop=%h, required 0",
                     busy, cache_trig, evt_if.evt_valid, evt_cnt, drop_cnt);
        end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_event();
        logic [31:0] want [6];
        int ct = 0;
        want = '{32'hA5030000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hB5040000};
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) cache_mem[8'(m_rd + 8'(i))] = 32'h11111111 * (i + 1);
        window_len = 4'd3;
        board_id = 4'd5;
        seen_q.delete();
        pulse();
        for (int i = 0; i < 12; i++) begin
            if (cache_trig) ct++;
            tick(1);
        end
        wait_drain("single");
        vec += 3;
        if (ct != 4) begin
            miss++;
            $display("FAIL single_cache_trig_cycles: got %0d, required 4", ct);
        end
        if (seen_q.size() != 6) begin
            miss++;
            $display("FAIL single_len: got %0d, required 6", seen_q.size());
        end else for (int i = 0; i < 6; i++) begin
            vec++;
            if (seen_q[i] !== want[i]) begin
                miss++;
                $display("FAIL single_word%0d: got %h, required %h", i, seen_q[i], want[i]);
            end
        end
        if (evt_cnt !== 16'd1) begin
            miss++;
            $display("FAIL single_evt_cnt: got %0d, required 1", evt_cnt);
        end
    endtask

    task automatic test_busy_drop();
        for (int i = 0; i < 16; i++) cache_mem[8'(m_rd + 8'(i))] = $urandom;
        window_len = 4'd15;
        board_id = 4'd9;
        seen_q.delete();
        pulse();
        tick(1);
        window_len = 4'd2;
        board_id = 4'd3;
        pulse();
        wait_drain("busy_drop");
        vec += 4;
        if (seen_q.size() != 18) begin
            miss++;
            $display("FAIL busy_drop_len: got %0d, required 18", seen_q.size());
        end else if (seen_q[17][31:24] !== 8'hB9) begin
            miss++;
            $display("FAIL busy_drop_trailer_tag: got %h, required b9", seen_q[17][31:24]);
        end
        if (seen_q.size() > 0 && seen_q[0][31:16] !== 16'hA90F) begin
            miss++;
            $display("FAIL busy_drop_header: got %h, required a90f", seen_q[0][31:16]);
        end
        if (evt_cnt !== 16'd2) begin
            miss++;
            $display("FAIL busy_drop_evt_cnt: got %0d, required 2", evt_cnt);
        end
        if (drop_cnt !== 16'd1) begin
            miss++;
            $display("FAIL busy_drop_dropped: got %0d, required 1", drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) cache_mem[8'(m_rd + 8'(i))] = $urandom;
        evt_if.evt_ready = 1'b0;
        window_len = 4'd15;
        board_id = 4'd6;
        seen_q.delete();
        pulse();
        tick(19);
        pulse();
        tick(19);
        pulse();
        tick(5);
        vec += 4;
        if (drop_cnt !== 16'd3) begin
            miss++;
            $display("FAIL bp_dropped: got %0d, required 3", drop_cnt);
        end
        if (evt_cnt !== 16'd3) begin
            miss++;
            $display("FAIL bp_evt_cnt: got %0d, required 3", evt_cnt);
        end
        if (evt_if.evt_valid !== 1'b1 || seen_q.size() != 0) begin
            miss++;
            $display("FAIL bp_hold: got valid=%b popped=%0d, required valid=1 popped=0", evt_if.evt_valid, seen_q.size());
        end
        if (evt_if.evt_data !== 32'hA60F0002) begin
            miss++;
            $display("FAIL bp_head: got %h, required a60f0002", evt_if.evt_data);
        end
        evt_if.evt_ready = 1'b1;
        wait_drain("release");
        vec += 2;
        if (seen_q.size() != 18) begin
            miss++;
            $display("FAIL release_len: got %0d, required 18", seen_q.size());
        end
        if (evt_if.evt_valid !== 1'b0) begin
            miss++;
            $display("FAIL release_valid: got %b, required 0", evt_if.evt_valid);
        end
        window_len = 4'd1;
        pulse();
        wait_drain("release_new");
        vec++;
        if (evt_cnt !== 16'd4 || seen_q.size() != 22) begin
            miss++;
            $display("FAIL release_new_event: got cnt=%0d words=%0d, required cnt=4 words=22", evt_cnt, seen_q.size());
        end
    endtask

    task automatic test_zero_words();
        cache_mem[m_rd] = 32'h0;
        window_len = 4'd0;
        board_id = 4'hC;
        seen_q.delete();
        pulse();
        wait_drain("zero");
        vec++;
        if (seen_q.size() != 3) begin
            miss++;
            $display("FAIL zero_len: got %0d, required 3", seen_q.size());
        end else begin
            vec += 2;
            if (seen_q[0] !== 32'hAC000004) begin
                miss++;
                $display("FAIL zero_header: got %h, required ac000004", seen_q[0]);
            end
            if (seen_q[2] !== 32'hBC000000) begin
                miss++;
                $display("FAIL zero_trailer: got %h, required bc000000", seen_q[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) cache_mem[i] = ($urandom % 5 == 0) ? 32'h0 : $urandom;
        for (int c = 0; c < 3000; c++) begin
            evt_if.evt_ready = ($urandom % 4) != 0;
            l1_trig = ($urandom % 6) == 0;
            window_len = 4'($urandom);
            board_id = 4'($urandom);
            tick(1);
        end
        l1_trig = 1'b0;
        evt_if.evt_ready = 1'b1;
        wait_drain("random");
    endtask

    task automatic test_mid_reset();
        evt_if.evt_ready = 1'b1;
        window_len = 4'd10;
        board_id = 4'd2;
        pulse();
        tick(3);
        reset_n = 1'b0;
        #1;
        vec++;
        if ({evt_if.evt_valid, cache_trig, busy, evt_cnt, drop_cnt} !== '0) begin
            miss++;
            $display("FAIL mid_reset: got valid=%b trig=%b busy=%b cnt=%h drop=%h, required 0",
                     evt_if.evt_valid, cache_trig, busy, evt_cnt, drop_cnt);
        end
        tick(1);
        reset_n = 1'b1;
        tick(2);
        window_len = 4'd1;
        board_id = 4'd7;
        seen_q.delete();
        pulse();
        wait_drain("after_reset");
        vec++;
        if (seen_q.size() != 4 || seen_q[0] !== 32'hA7010000) begin
            miss++;
            $display("FAIL after_reset_event: got words=%0d head=%h, required words=4 head=a7010000",
                     seen_q.size(), seen_q.size() > 0 ? seen_q[0] : 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) cache_mem[i] = $urandom;
        evt_if.evt_ready = 1'b1;
        test_reset();
        test_single_event();
        test_busy_drop();
        test_backpressure();
        test_zero_words();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
